// File: rtl/qei_velocity.sv
// Velocity estimator for a quadrature position counter: samples the position
// every PERIOD cycles, reports the saturated window delta and a 4-window mean.
module qei_velocity #(
  parameter int PERIOD    = 1000,
  parameter int VEL_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [31:0]                 qei_position,
  input  logic                        vel_enable,
  output logic signed [VEL_WIDTH-1:0] vel_value,
  output logic                        vel_valid,
  output logic                        vel_saturated,
  output logic signed [VEL_WIDTH-1:0] vel_average,
  output logic                        vel_avg_valid,
  output logic [1:0]                  vel_state
);

  // Handshake: vel_valid is a one-cycle strobe with no back-pressure; the
  // consumer must take vel_value/vel_saturated/vel_average in that cycle,
  // after which they hold until the next strobe.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int CW = 24;
  localparam logic [CW-1:0] TERM = CW'(PERIOD - 1);
  localparam logic signed [31:0] VMAX = (32'sd1 <<< (VEL_WIDTH - 1)) - 32'sd1;
  localparam logic signed [31:0] VMIN = -(32'sd1 <<< (VEL_WIDTH - 1));

  state_t                      state;
  logic [CW-1:0]               cnt;
  logic [31:0]                 prev;
  logic [2:0]                  fill;
  logic signed [VEL_WIDTH-1:0] hist [4];

  // Sample captured on the terminal-count edge, published one edge later.
  logic                        pend;
  logic signed [VEL_WIDTH-1:0] pend_val;
  logic                        pend_sat;

  logic signed [31:0]          delta;
  logic signed [VEL_WIDTH-1:0] clamp_val;
  logic                        clamp_sat;
  logic signed [VEL_WIDTH+1:0] hist_sum;

  assign vel_state = state;

  // Modulo-2^32 difference read as signed handles counter wrap in both directions.
  assign delta = qei_position - prev;

  always_comb begin
    clamp_sat = 1'b0;
    clamp_val = delta[VEL_WIDTH-1:0];
    if (delta > VMAX) begin
      clamp_val = VMAX[VEL_WIDTH-1:0];
      clamp_sat = 1'b1;
    end else if (delta < VMIN) begin
      clamp_val = VMIN[VEL_WIDTH-1:0];
      clamp_sat = 1'b1;
    end
  end

  always_comb begin
    hist_sum = '0;
    for (int i = 0; i < 4; i++) begin
      hist_sum = hist_sum + (VEL_WIDTH + 2)'(hist[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      prev          <= '0;
      fill          <= '0;
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      pend          <= 1'b0;
      pend_val      <= '0;
      pend_sat      <= 1'b0;
      vel_value     <= '0;
      vel_valid     <= 1'b0;
      vel_saturated <= 1'b0;
      vel_average   <= '0;
      vel_avg_valid <= 1'b0;
    end else begin
      vel_valid <= 1'b0;
      pend      <= 1'b0;
      case (state)
        IDLE: begin
          if (vel_enable) begin
            prev  <= qei_position;
            cnt   <= '0;
            fill  <= '0;
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            state <= FILL;
          end
        end
        FILL, RUN: begin
          if (!vel_enable) begin
            // Disable wins over a terminal count or a pending publish.
            state         <= IDLE;
            cnt           <= '0;
            fill          <= '0;
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            vel_avg_valid <= 1'b0;
          end else begin
            if (pend) begin
              vel_value     <= pend_val;
              vel_saturated <= pend_sat;
              vel_average   <= VEL_WIDTH'(hist_sum >>> 2);
              vel_valid     <= 1'b1;
              if (state == RUN) vel_avg_valid <= 1'b1;
            end
            if (cnt == TERM) begin
              cnt      <= '0;
              prev     <= qei_position;
              pend     <= 1'b1;
              pend_val <= clamp_val;
              pend_sat <= clamp_sat;
              hist[3]  <= hist[2];
              hist[2]  <= hist[1];
              hist[1]  <= hist[0];
              hist[0]  <= clamp_val;
              if (fill == 3'd3) state <= RUN;
              if (fill != 3'd4) fill <= fill + 3'd1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qei_velocity.sv
// Directed bench for qei_velocity at PERIOD=4, VEL_WIDTH=16 with
// hand-computed window deltas and 4-window averages.
module tb_qei_velocity;

  localparam int PERIOD = 4;
  localparam int VW     = 16;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [31:0]          qei_position;
  logic                 vel_enable;
  logic signed [VW-1:0] vel_value;
  logic                 vel_valid;
  logic                 vel_saturated;
  logic signed [VW-1:0] vel_average;
  logic                 vel_avg_valid;
  logic [1:0]           vel_state;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  qei_velocity #(.PERIOD(PERIOD), .VEL_WIDTH(VW)) dut (
    .clock         (clock),
    .reset         (reset),
    .qei_position  (qei_position),
    .vel_enable    (vel_enable),
    .vel_value     (vel_value),
    .vel_valid     (vel_valid),
    .vel_saturated (vel_saturated),
    .vel_average   (vel_average),
    .vel_avg_valid (vel_avg_valid),
    .vel_state     (vel_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  function automatic logic [31:0] sx(input logic [VW-1:0] v);
    return {{(32 - VW){v[VW-1]}}, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // scoreboard: every vel_valid pulse must match the next expected value
  always @(negedge clock) begin
    if (vel_valid === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_valid", {31'b0, vel_valid}, 32'd0);
      else check("vel_value", sx(vel_value), exp_q.pop_front());
    end
  end

  // driver tasks
  // Enters at the negedge where cnt==1 of a window; leaves at cnt==1 of the next.
  task automatic window(input string tag, input logic [31:0] pos, input int ev,
                        input logic es, input int ea, input logic eav);
    qei_position = pos;
    exp_q.push_back(ev);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    check({tag, "_nopulse"}, {31'b0, vel_valid}, 32'd0);
    @(negedge clock);
    check({tag, "_valid"}, {31'b0, vel_valid}, 32'd1);
    check({tag, "_sat"},   {31'b0, vel_saturated}, {31'b0, es});
    check({tag, "_avg"},   sx(vel_average), ea);
    check({tag, "_avgv"},  {31'b0, vel_avg_valid}, {31'b0, eav});
  endtask

  task automatic enable_start(input logic [31:0] pos);
    qei_position = pos;
    vel_enable   = 1'b1;
    @(negedge clock);
    check("capture_state", {30'b0, vel_state}, 32'd1);
    check("capture_novalid", {31'b0, vel_valid}, 32'd0);
    @(negedge clock);
  endtask

  task automatic disable_check(input string tag, input int held);
    vel_enable = 1'b0;
    @(negedge clock);
    check({tag, "_state"}, {30'b0, vel_state}, 32'd0);
    check({tag, "_avgv"},  {31'b0, vel_avg_valid}, 32'd0);
    check({tag, "_valid"}, {31'b0, vel_valid}, 32'd0);
    check({tag, "_held"},  sx(vel_value), held);
  endtask

  initial begin
    reset        = 1'b1;
    vel_enable   = 1'b0;
    qei_position = 32'd0;
    repeat (3) @(negedge clock);
    check("rst_value", sx(vel_value), 32'd0);
    check("rst_valid", {31'b0, vel_valid}, 32'd0);
    check("rst_sat",   {31'b0, vel_saturated}, 32'd0);
    check("rst_avg",   sx(vel_average), 32'd0);
    check("rst_avgv",  {31'b0, vel_avg_valid}, 32'd0);
    check("rst_state", {30'b0, vel_state}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_hold", {30'b0, vel_state}, 32'd0);

    // steady +3 per window
    enable_start(32'd0);
    window("s29a", 32'd3,  3, 1'b0, 0, 1'b0);
    window("s29b", 32'd6,  3, 1'b0, 1, 1'b0);
    window("s29c", 32'd9,  3, 1'b0, 2, 1'b0);
    window("s29d", 32'd12, 3, 1'b0, 3, 1'b1);
    window("s29e", 32'd15, 3, 1'b0, 3, 1'b1);
    disable_check("dis1", 3);

    // wrap both ways, then saturation
    enable_start(32'hFFFF_FFFE);
    window("s30a", 32'h0000_0001, 3,  1'b0, 0, 1'b0);
    window("s30b", 32'hFFFF_FFFF, -2, 1'b0, 0, 1'b0);
    window("s31a", 32'd39999,      32767,  1'b1, 8192, 1'b0);
    window("s31b", 32'hFFFF_FFFF, -32768, 1'b1, 0,    1'b1);
    window("s31c", 32'd4,          5,      1'b0, 0,    1'b1);
    disable_check("dis2", 5);

    // floor rounding of the mean
    enable_start(32'd100);
    window("s32a", 32'd99,  -1, 1'b0, -1, 1'b0);
    window("s32b", 32'd99,   0, 1'b0, -1, 1'b0);
    window("s32c", 32'd99,   0, 1'b0, -1, 1'b0);
    window("s32d", 32'd99,   0, 1'b0, -1, 1'b1);
    window("s32e", 32'd100,  1, 1'b0,  0, 1'b1);
    window("s32f", 32'd101,  1, 1'b0,  0, 1'b1);
    window("s32g", 32'd102,  1, 1'b0,  0, 1'b1);
    window("s32h", 32'd102,  0, 1'b0,  0, 1'b1);
    window("s32i", 32'd109,  7, 1'b0,  2, 1'b1);

    // disable exactly on the terminal-count cycle
    @(negedge clock);
    @(negedge clock);
    vel_enable   = 1'b0;
    qei_position = 32'd200;
    @(negedge clock);
    check("s33_state", {30'b0, vel_state}, 32'd0);
    check("s33_valid", {31'b0, vel_valid}, 32'd0);
    check("s33_avgv",  {31'b0, vel_avg_valid}, 32'd0);
    check("s33_held",  sx(vel_value), 32'd7);
    @(negedge clock);
    check("s33_valid2", {31'b0, vel_valid}, 32'd0);
    enable_start(32'd500);
    window("s33r", 32'd510, 10, 1'b0, 2, 1'b0);

    // reset two cycles into a window with enable held
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("s34_value", sx(vel_value), 32'd0);
    check("s34_avg",   sx(vel_average), 32'd0);
    check("s34_sat",   {31'b0, vel_saturated}, 32'd0);
    check("s34_avgv",  {31'b0, vel_avg_valid}, 32'd0);
    check("s34_valid", {31'b0, vel_valid}, 32'd0);
    check("s34_state", {30'b0, vel_state}, 32'd0);
    reset        = 1'b0;
    qei_position = 32'd1000;
    @(negedge clock);
    check("s34_recap", {30'b0, vel_state}, 32'd1);
    @(negedge clock);
    window("s34r", 32'd1004, 4, 1'b0, 1, 1'b0);

    repeat (2) @(negedge clock);
    check("exp_q_empty", exp_q.size(), 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/qei_velocity.md
QEI_VELOCITY -- requirements
Module: qei_velocity

Interface
REQ-001 SHALL have parameter PERIOD, default 1000: sample window length in clock cycles, legal range 2..2^24-1.
REQ-002 SHALL have parameter VEL_WIDTH, default 16: width of the signed velocity outputs, legal range 8..31.
REQ-003 SHALL have port clock, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port qei_position, input, 32: position count from the qei block, treated as modulo 2^32.
REQ-006 SHALL have port vel_enable, input, 1: level; high runs measurement, low returns to IDLE.
REQ-007 SHALL have port vel_value, output, VEL_WIDTH: signed position delta over the last window, saturated.
REQ-008 SHALL have port vel_valid, output, 1: one-cycle pulse marking a new vel_value.
REQ-009 SHALL have port vel_saturated, output, 1: high when the current vel_value was clamped.
REQ-010 SHALL have port vel_average, output, VEL_WIDTH: signed mean of the last 4 window deltas.
REQ-011 SHALL have port vel_avg_valid, output, 1: level; high when vel_average covers 4 real windows.

Function
REQ-012 SHALL implement FSM states IDLE, FILL and RUN.
REQ-013 In IDLE with vel_enable=1, SHALL capture prev<=qei_position, clear cnt, clear the history fill count, and go to FILL.
REQ-014 In FILL and RUN, cnt SHALL increment every cycle; when cnt==PERIOD-1 (terminal count), cnt<=0 and a sample is taken.
REQ-015 At a sample, SHALL compute delta = qei_position - prev as a 32-bit modulo difference read as signed, then set prev<=qei_position.
REQ-016 Successive samples SHALL be exactly PERIOD cycles apart; the first sample SHALL come PERIOD cycles after the IDLE->FILL capture.
REQ-017 Saturation: delta > 2^(VEL_WIDTH-1)-1 SHALL clamp to max and delta < -2^(VEL_WIDTH-1) SHALL clamp to min; vel_saturated SHALL be 1 when clamped and 0 otherwise, updated with vel_value.
REQ-018 vel_value, vel_saturated and vel_average SHALL be registered and update on the clock edge after the sampling edge, with vel_valid=1 for exactly that one cycle.
REQ-019 The clamped delta SHALL be pushed into a 4-entry history (oldest discarded).
REQ-020 vel_average SHALL be the sum of the 4 history entries (VEL_WIDTH+2 bits) arithmetically shifted right by 2, rounding toward minus infinity; empty entries read as 0.
REQ-021 FILL SHALL go to RUN on the 4th sample; vel_avg_valid SHALL rise together with that 4th vel_valid pulse and stay high while in RUN.
REQ-022 vel_enable=0 in FILL or RUN SHALL return to IDLE on the next edge, clear history and vel_avg_valid, and hold vel_value and vel_saturated; vel_valid SHALL be 0.
REQ-023 vel_enable falling on a terminal-count cycle SHALL take priority: no sample and no vel_valid.
REQ-024 Position wrap (0xFFFFFFFF->0x00000000) SHALL yield a delta of +1, and the reverse wrap SHALL yield -1.
REQ-025 Outputs SHALL hold between vel_valid pulses.

Reset
REQ-026 reset=1 SHALL, at the next edge, force state IDLE, with cnt, prev, history, vel_value, vel_average, vel_valid, vel_saturated and vel_avg_valid all 0.
REQ-027 reset SHALL take priority over vel_enable and over a terminal count in the same cycle.
REQ-028 Reset asserted mid-window SHALL abort the window with no vel_valid pulse.

Verification (PERIOD=4, VEL_WIDTH=16)
REQ-029 Scenario: position steps +3 per window, enable held -> vel_valid pulses every 4 cycles, vel_value=3, vel_saturated=0, and vel_avg_valid rises with the 4th pulse with vel_average=3.
REQ-030 Scenario: prev=0xFFFFFFFE, position 0x00000001 at the sample -> vel_value=+3; prev=0x00000001, position 0xFFFFFFFF -> vel_value=-2.
REQ-031 Scenario: delta=+40000 -> vel_value=32767, vel_saturated=1; delta=-40000 -> vel_value=-32768, vel_saturated=1; next delta=5 -> vel_saturated=0.
REQ-032 Scenario: deltas -1,0,0,0 -> vel_average=-1 (floor); deltas 1,1,1,0 -> vel_average=0.
REQ-033 Scenario: vel_enable dropped on a terminal-count cycle -> no vel_valid, vel_avg_valid=0, vel_value held; re-enable -> first vel_valid exactly 4 cycles after the capture edge plus 1.
REQ-034 Scenario: reset pulsed 2 cycles into a window with vel_enable=1 -> all outputs 0, no pulse from the aborted window; measurement restarts from IDLE.
